uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set clock cycles per serial bit; legal values are even and at least 4.
REQ-002 Port clock  input  1  SHALL be the single clock; all flops SHALL update on its rising edge.
REQ-003 Port resetN  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port serial_in  input  1  SHALL be the asynchronous serial line: idle high, 8N1, LSB first.
REQ-005 Port rd_ack  input  1  SHALL be the consumer's one-cycle acknowledge of the current byte.
REQ-006 Port data  output  8  SHALL be the last correctly framed byte, held stable between loads.
REQ-007 Port data_rdy  output  1  SHALL be high while data holds an unacknowledged byte.
REQ-008 Port frame_err  output  1  SHALL be a one-cycle pulse on a bad stop bit.
REQ-009 Port overrun  output  1  SHALL be a sticky flag, set when a byte is loaded while data_rdy=1.
REQ-010 Port busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-011 serial_in SHALL pass through a 2-flop synchronizer (serial_s); all decisions SHALL use serial_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: on serial_s=0, go to START and clear the baud counter.
REQ-014 START: at count CLKS_PER_BIT/2-1, sample serial_s; 0 goes to DATA with counter cleared; 1 (glitch) goes to IDLE with no other effect.
REQ-015 DATA: at count CLKS_PER_BIT-1, assert shift_en for one cycle, increment a 3-bit bit_cnt and clear the counter; after the sample with bit_cnt=7, go to STOP.
REQ-016 STOP: at count CLKS_PER_BIT-1, sample serial_s; 1 loads the shift register into data, sets data_rdy and goes to IDLE; 0 pulses frame_err, leaves data/data_rdy unchanged and goes to IDLE.
REQ-017 data_rdy SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after serial_in falls (154 for the default).
REQ-018 rd_ack with data_rdy=1 SHALL clear data_rdy on the next edge; rd_ack with data_rdy=0 SHALL be ignored.
REQ-019 A load while data_rdy=1 and rd_ack=0 SHALL overwrite data, keep data_rdy=1 and set overrun.
REQ-020 A load coinciding with rd_ack SHALL overwrite data, keep data_rdy=1 and SHALL NOT set overrun.
REQ-021 overrun SHALL clear only on reset.
REQ-022 Reception SHALL proceed regardless of data_rdy; a new frame may start the cycle after STOP returns to IDLE.

Reset
REQ-023 resetN low SHALL immediately force: state IDLE, counter 0, bit_cnt 0, synchronizer 1'b1, shift register 8'h00, data 8'h00, data_rdy 0, frame_err 0, overrun 0, busy 0.
REQ-024 Reset mid-frame SHALL abandon the frame; after release, the block SHALL wait for a fresh falling edge on serial_s.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum type and the default CLKS_PER_BIT constant.
REQ-026 Sub-module uart_shifter (8-bit right shift, serial in at MSB, shift_en, async active-low clear) SHALL be instantiated once.
REQ-027 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap unobserved.

Verification (CLKS_PER_BIT=16)
REQ-028 Frame 8'hA5 with good stop -> data=8'hA5, data_rdy rises 154 cycles after the start edge, frame_err=0.
REQ-029 Low glitch of 4 cycles on idle line -> FSM returns to IDLE with no shift, data_rdy=0, frame_err=0.
REQ-030 Frame 8'h3C with stop bit 0 -> one-cycle frame_err pulse, data and data_rdy unchanged.
REQ-031 Frames 8'h11 then 8'h22 with no rd_ack -> data=8'h22, data_rdy=1, overrun=1; repeat with rd_ack on the load cycle -> overrun stays 0.
REQ-032 resetN pulsed low during data bit 4 of 8'hFF -> all outputs at reset values; next frame 8'h0F -> data=8'h0F.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART receive controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int unsigned c_DEFAULT_CLKS_PER_BIT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_shifter.sv
// ============================================================================
// Module   : uart_shifter
// Brief    : 8-bit right shift register, serial input enters at the MSB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_shifter (
   input  logic       clock,
   input  logic       resetN,
   input  logic       shift_en,
   input  logic       serial_bit,
   output logic [7:0] q
);

   logic [7:0] r_q;

   // LSB-first line: after eight shifts the first bit received sits in bit 0
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_q <= 8'h00;
      end else if (shift_en) begin
         r_q <= {serial_bit, r_q[7:1]};
      end
   end

   assign q = r_q;

endmodule : uart_shifter

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : 8N1 UART receiver with holding register, ready/ack handshake,
//            framing-error pulse and sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT
) (
   input  logic       clock,
   input  logic       resetN,
   input  logic       serial_in,
   input  logic       rd_ack,
   output logic [7:0] data,
   output logic       data_rdy,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int             c_CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   logic               r_sync1;
   logic               r_serial_s;
   rx_state_t          r_state;
   rx_state_t          w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic [2:0]         r_bit_cnt;
   logic [2:0]         w_bit_cnt_nxt;
   logic               w_shift_en;
   logic               w_load;
   logic               w_frame_err;
   logic [7:0]         w_shift_q;
   logic [7:0]         r_data;
   logic               r_data_rdy;
   logic               r_frame_err;
   logic               r_overrun;

   // Two-flop synchronizer; resets to the idle (mark) level
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_sync1    <= 1'b1;
         r_serial_s <= 1'b1;
      end else begin
         r_sync1    <= serial_in;
         r_serial_s <= r_sync1;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= 3'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
      end
   end

   // Every state clears the counter at its terminal count, so it never wraps
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt + c_ONE;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_en    = 1'b0;
      w_load        = 1'b0;
      w_frame_err   = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt     = '0;
            w_bit_cnt_nxt = 3'd0;
            if (!r_serial_s) begin
               w_state_nxt = START;
            end
         end
         START: begin
            if (r_cnt == c_HALF) begin
               w_cnt_nxt   = '0;
               w_state_nxt = r_serial_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_cnt == c_FULL) begin
               w_cnt_nxt     = '0;
               w_shift_en    = 1'b1;
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt = STOP;
               end
            end
         end
         STOP: begin
            if (r_cnt == c_FULL) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
               if (r_serial_s) begin
                  w_load = 1'b1;
               end else begin
                  w_frame_err = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   uart_shifter u_shifter (
      .clock      (clock),
      .resetN     (resetN),
      .shift_en   (w_shift_en),
      .serial_bit (r_serial_s),
      .q          (w_shift_q)
   );

   // An ack landing on the load cycle consumes the old byte, so no overrun
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_data      <= 8'h00;
         r_data_rdy  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_frame_err;
         if (w_load) begin
            r_data     <= w_shift_q;
            r_data_rdy <= 1'b1;
            if (r_data_rdy && !rd_ack) begin
               r_overrun <= 1'b1;
            end
         end else if (rd_ack && r_data_rdy) begin
            r_data_rdy <= 1'b0;
         end
      end
   end

   assign data      = r_data;
   assign data_rdy  = r_data_rdy;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != IDLE);

endmodule : uart_rx_ctrl

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Directed, scoreboard-based bench for uart_rx_ctrl (16 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

   localparam int c_CPB = 16;

   logic       clock = 1'b0;
   logic       resetN;
   logic       serial_in;
   logic       rd_ack;
   logic [7:0] data;
   logic       data_rdy;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int         n_vec = 0;
   int         n_err = 0;
   int         fe_cnt = 0;
   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   logic [7:0] m_data;
   logic [7:0] prev_data;
   logic       prev_rdy;

   int         lat;
   logic       busy_mid;
   logic [11:0] snap;

   always #5 clock = ~clock;

   uart_rx_ctrl #(.CLKS_PER_BIT(c_CPB)) dut (
      .clock     (clock),
      .resetN    (resetN),
      .serial_in (serial_in),
      .rd_ack    (rd_ack),
      .data      (data),
      .data_rdy  (data_rdy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   // Output monitor: records every load ({0,data}) and framing error ({1,data})
   always @(negedge clock) begin
      if (frame_err) begin
         fe_cnt++;
         obs_q.push_back({1'b1, data});
      end else if (resetN && ((data_rdy && !prev_rdy) || (data !== prev_data))) begin
         obs_q.push_back({1'b0, data});
      end
      prev_rdy  = data_rdy;
      prev_data = data;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_event(input string tag);
      logic [8:0] e;
      logic [8:0] o;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
      if (obs_q.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: observed no output expected %0h", tag, e);
      end else begin
         o = obs_q.pop_front();
         check(tag, {23'd0, o}, {23'd0, e});
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      resetN = 1'b0;
      @(negedge clock);
      @(negedge clock);
      resetN = 1'b1;
      m_data = 8'h00;
      obs_q.delete();
      exp_q.delete();
   endtask

   // Drives one 8N1 frame from a negedge; rd_ack optionally coincides with the
   // load edge; rst_at >= 0 pulses reset at that sample index.
   task automatic frame(input logic [7:0] b, input logic stop, input logic ack,
                        input int rst_at, output int lat_o, output logic busy_o,
                        output logic [11:0] snap_o);
      logic [9:0] bits;
      logic       was_rdy;
      bits    = {stop, b, 1'b0};
      lat_o   = -1;
      busy_o  = 1'b0;
      snap_o  = '0;
      was_rdy = data_rdy;
      if (rst_at < 0) begin
         if (stop) begin
            exp_q.push_back({1'b0, b});
            m_data = b;
         end else begin
            exp_q.push_back({1'b1, m_data});
         end
      end
      for (int k = 0; k < 10 * c_CPB; k++) begin
         serial_in = bits[k / c_CPB];
         rd_ack    = ack && (k == 2 + c_CPB / 2 + 9 * c_CPB);
         if (k == rst_at) begin
            resetN = 1'b0;
            #1;
            snap_o = {data, data_rdy, frame_err, overrun, busy};
         end
         if (rst_at >= 0 && k == rst_at + 2) begin
            resetN = 1'b1;
            m_data = 8'h00;
         end
         @(negedge clock);
         if (lat_o < 0 && !was_rdy && data_rdy) lat_o = k;
         was_rdy = data_rdy;
         if (k == 80) busy_o = busy;
      end
      rd_ack    = 1'b0;
      serial_in = 1'b1;
      repeat (20) @(negedge clock);
   endtask

   initial begin
      resetN    = 1'b0;
      serial_in = 1'b1;
      rd_ack    = 1'b0;
      m_data    = 8'h00;
      repeat (3) @(negedge clock);
      check("reset_data", {24'd0, data}, 32'h00);
      check("reset_rdy", {31'd0, data_rdy}, 32'd0);
      check("reset_ferr", {31'd0, frame_err}, 32'd0);
      check("reset_ovr", {31'd0, overrun}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      resetN = 1'b1;
      repeat (5) @(negedge clock);
      obs_q.delete();

      // Good frame A5: value, latency, busy while receiving
      frame(8'hA5, 1'b1, 1'b0, -1, lat, busy_mid, snap);
      expect_event("a5_event");
      check("a5_latency", lat, 2 + c_CPB / 2 + 9 * c_CPB);
      check("a5_busy_mid", {31'd0, busy_mid}, 32'd1);
      check("a5_rdy", {31'd0, data_rdy}, 32'd1);
      check("a5_ferr_cnt", fe_cnt, 0);

      // Acknowledge, then a stray ack with nothing pending
      rd_ack = 1'b1;
      @(negedge clock);
      rd_ack = 1'b0;
      check("ack_clears_rdy", {31'd0, data_rdy}, 32'd0);
      rd_ack = 1'b1;
      @(negedge clock);
      rd_ack = 1'b0;
      @(negedge clock);
      check("stray_ack_rdy", {31'd0, data_rdy}, 32'd0);
      check("stray_ack_ovr", {31'd0, overrun}, 32'd0);

      // Four-cycle low glitch on an idle line
      serial_in = 1'b0;
      repeat (4) @(negedge clock);
      check("glitch_busy_start", {31'd0, busy}, 32'd1);
      serial_in = 1'b1;
      repeat (40) @(negedge clock);
      check("glitch_busy_end", {31'd0, busy}, 32'd0);
      check("glitch_rdy", {31'd0, data_rdy}, 32'd0);
      check("glitch_no_output", obs_q.size(), 0);
      check("glitch_ferr_cnt", fe_cnt, 0);
      check("glitch_data", {24'd0, data}, {24'd0, m_data});

      // Bad stop bit on 3C
      frame(8'h3C, 1'b0, 1'b0, -1, lat, busy_mid, snap);
      expect_event("3c_ferr_event");
      check("3c_ferr_one_cycle", fe_cnt, 1);
      check("3c_data_kept", {24'd0, data}, 32'hA5);
      check("3c_rdy_kept", {31'd0, data_rdy}, 32'd0);

      // Overrun: two frames without ack
      frame(8'h11, 1'b1, 1'b0, -1, lat, busy_mid, snap);
      expect_event("ovr_11_event");
      check("ovr_11_ovr", {31'd0, overrun}, 32'd0);
      frame(8'h22, 1'b1, 1'b0, -1, lat, busy_mid, snap);
      expect_event("ovr_22_event");
      check("ovr_data", {24'd0, data}, 32'h22);
      check("ovr_rdy", {31'd0, data_rdy}, 32'd1);
      check("ovr_set", {31'd0, overrun}, 32'd1);
      rd_ack = 1'b1;
      @(negedge clock);
      rd_ack = 1'b0;
      @(negedge clock);
      check("ovr_sticky", {31'd0, overrun}, 32'd1);

      // Same pair, but the ack coincides with the second load
      do_reset();
      check("ovr_reset_clear", {31'd0, overrun}, 32'd0);
      frame(8'h11, 1'b1, 1'b0, -1, lat, busy_mid, snap);
      expect_event("ack_11_event");
      frame(8'h22, 1'b1, 1'b1, -1, lat, busy_mid, snap);
      expect_event("ack_22_event");
      check("ack_load_data", {24'd0, data}, 32'h22);
      check("ack_load_rdy", {31'd0, data_rdy}, 32'd1);
      check("ack_load_no_ovr", {31'd0, overrun}, 32'd0);

      // Reset during data bit 4 of FF, then a clean 0F
      frame(8'hFF, 1'b1, 1'b0, 5 * c_CPB + 8, lat, busy_mid, snap);
      check("midrst_outputs", {20'd0, snap}, 32'h000);
      check("midrst_busy_after", {31'd0, busy}, 32'd0);
      check("midrst_rdy_after", {31'd0, data_rdy}, 32'd0);
      obs_q.delete();
      frame(8'h0F, 1'b1, 1'b0, -1, lat, busy_mid, snap);
      expect_event("post_rst_0f_event");
      check("post_rst_data", {24'd0, data}, 32'h0F);
      check("post_rst_rdy", {31'd0, data_rdy}, 32'd1);
      check("post_rst_latency", lat, 2 + c_CPB / 2 + 9 * c_CPB);
      check("no_extra_output", obs_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_uart_rx_ctrl

`default_nettype wire
